// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-draining UART transmitter.
// UART_TX_PARITY_EN adds an even-parity bit, making frames 11 bits long.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;

  function automatic int unsigned frame_bits();
`ifdef UART_TX_PARITY_EN
    return 11;
`else
    return 10;
`endif
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side connection between the byte FIFO and its single reader.
interface fifo_uart_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              fifo_rd;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;

  // master is the reader (the transmitter), slave is the FIFO.
  modport master (output fifo_rd, input fifo_empty, input fifo_data);
  modport slave  (input fifo_rd, output fifo_empty, output fifo_data);
endinterface

// File: rtl/uart_baud_gen.sv
// Per-bit baud counter: counts 0..CLKS_PER_BIT-1 and pulses bit_tick_o on the last count.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic bit_tick_o
);
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign bit_tick_o = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear_i || bit_tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous byte FIFO and serializes each byte as a UART frame.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic [7:0]            frame_cnt
);
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [7:0]        frame_q, frame_d;
  logic              tx_q, tx_d;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              baud_clr;
  logic              bit_tick;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (baud_clr),
    .bit_tick_o (bit_tick)
  );

  assign fifo.fifo_rd = rd_q;
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign frame_cnt    = frame_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    baud_clr = (state_q == IDLE) || (state_q == READ) || (state_q == FETCH);

    case (state_q)
      IDLE: begin
        if (tx_en && !fifo.fifo_empty) state_d = READ;
      end
      READ: begin
        state_d = FETCH;
      end
      FETCH: begin
        shift_d = fifo.fifo_data;
        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
        par_d   = ^fifo.fifo_data;
`endif
        state_d = START;
      end
      START: begin
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) begin
          frame_d = frame_q + 8'd1;
          state_d = (tx_en && !fifo.fifo_empty) ? READ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    rd_d   = (state_d == READ);
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO, frame decoder and expected-frame scoreboard.
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_en = 1'b0;
  logic       tx;
  logic       busy;
  logic [7:0] frame_cnt;

  fifo_uart_tx_if #(.DATA_W(8)) fif ();

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (tx_en),
    .fifo      (fif.master),
    .tx        (tx),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  int unsigned  n_checks = 0;
  int unsigned  n_pass   = 0;
  int unsigned  cyc      = 0;
  int unsigned  rd_count = 0;
  int unsigned  exp_fc   = 0;
  int unsigned  nb;
  logic [7:0]   fq[$];
  logic [10:0]  sb[$];
  int unsigned  rd_cycles[$];

  logic         rx_active = 1'b0;
  int unsigned  rx_cyc    = 0;
  logic [10:0]  rx_bits;
  logic         rx_glitch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic p);
    logic [10:0] f;
    f      = '0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = p;
    f[10]  = 1'b1;
`else
    f[9]   = 1'b1;
    if (p) f[10] = 1'b0;
`endif
    return f;
  endfunction

  task automatic push(input logic [7:0] d, input logic p);
    fq.push_back(d);
    sb.push_back(make_frame(d, p));
    fif.fifo_empty = 1'b0;
  endtask

  // One clock: FIFO read model, read-strobe checks and frame decoder.
  task automatic step();
    logic        rd_now;
    int unsigned bi;
    rd_now = fif.fifo_rd;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_now) begin
      if (fq.size() == 0) fail("read_of_empty_fifo");
      else fif.fifo_data = fq.pop_front();
      fif.fifo_empty = (fq.size() == 0);
    end
    if (fif.fifo_rd === 1'b1) begin
      rd_count++;
      rd_cycles.push_back(cyc);
      check("rd_while_empty", 32'(fif.fifo_empty), 32'd0);
      check("rd_single_cycle", 32'(rd_now), 32'd0);
    end
    if (!rx_active && tx === 1'b0) begin
      rx_active = 1'b1;
      rx_cyc    = 0;
      rx_bits   = '0;
      rx_glitch = 1'b0;
    end
    if (rx_active) begin
      bi = rx_cyc / CPB;
      if (rx_cyc % CPB == 0) rx_bits[bi] = tx;
      else if (tx !== rx_bits[bi]) rx_glitch = 1'b1;
      if (rx_cyc == nb * CPB - 1) begin
        rx_active = 1'b0;
        if (sb.size() == 0) fail("unexpected_frame");
        else check("frame_bits", {20'd0, rx_glitch, rx_bits}, {20'd0, 1'b0, sb.pop_front()});
      end else begin
        rx_cyc++;
      end
    end
  endtask

  task automatic wait_done(input int unsigned budget, input bit need_empty);
    int unsigned n;
    bit          ok;
    n = 0;
    do begin
      step();
      n++;
      ok = !busy && !rx_active && (!need_empty || (fq.size() == 0 && sb.size() == 0));
    end while (!ok && n < budget);
    if (!ok) fail("timeout_waiting_idle");
  endtask

  vec_t        vecs[8];
  int unsigned n0, rc0;
  bit          bad;
  logic [7:0]  b;

  initial begin
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h3C, 1'b0};
    vecs[4] = '{8'h07, 1'b1};
    vecs[5] = '{8'h03, 1'b0};
    vecs[6] = '{8'h80, 1'b1};
    vecs[7] = '{8'h5B, 1'b1};

    nb             = frame_bits();
    fif.fifo_empty = 1'b1;
    fif.fifo_data  = '0;

    // Reset state, then a long idle stretch with tx_en high and FIFO empty.
    repeat (3) step();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rd", 32'(fif.fifo_rd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst   = 1'b1;
    tx_en = 1'b1;
    bad   = 1'b0;
    repeat (100) begin
      step();
      if (tx !== 1'b1 || fif.fifo_rd !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd0) bad = 1'b1;
    end
    check("idle_hold", 32'(bad), 32'd0);

    // Single bytes: strobe latency, start-bit latency, frame contents, busy length.
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].data, vecs[i].par);
      n0 = cyc;
      step();
      check("lat_rd_high", 32'(fif.fifo_rd), 32'd1);
      step();
      check("lat_rd_low", 32'(fif.fifo_rd), 32'd0);
      check("lat_tx_high", 32'(tx), 32'd1);
      step();
      check("lat_tx_start", 32'(tx), 32'd0);
      wait_done(200, 1'b1);
      check("busy_len", cyc - n0, 3 + nb * CPB);
      exp_fc++;
      check("frame_cnt", 32'(frame_cnt), exp_fc % 256);
      check("idle_tx", 32'(tx), 32'd1);
    end

    // Back-to-back frames: read strobes separated by one frame plus two cycles.
    tx_en = 1'b0;
    step();
    push(8'h00, 1'b0);
    push(8'hFF, 1'b0);
    rd_cycles.delete();
    rc0   = rd_count;
    tx_en = 1'b1;
    wait_done(300, 1'b1);
    check("b2b_rd_pulses", rd_count - rc0, 2);
    if (rd_cycles.size() == 2) check("b2b_rd_gap", rd_cycles[1] - rd_cycles[0], nb * CPB + 2);
    else fail("b2b_rd_gap");
    exp_fc += 2;
    check("b2b_frame_cnt", 32'(frame_cnt), exp_fc % 256);

    // tx_en dropped mid-DATA: current frame finishes, queued bytes wait.
    tx_en = 1'b0;
    step();
    push(8'h3C, 1'b0);
    push(8'hA1, 1'b1);
    push(8'hB2, 1'b0);
    rc0   = rd_count;
    tx_en = 1'b1;
    repeat (3 + 3 * CPB) step();
    tx_en = 1'b0;
    wait_done(200, 1'b0);
    exp_fc++;
    check("drop_frame_cnt", 32'(frame_cnt), exp_fc % 256);
    repeat (20) step();
    check("drop_no_more_rd", rd_count - rc0, 1);
    check("drop_idle_tx", 32'(tx), 32'd1);
    check("drop_idle_busy", 32'(busy), 32'd0);
    tx_en = 1'b1;
    wait_done(400, 1'b1);
    check("resume_rd_pulses", rd_count - rc0, 3);
    exp_fc += 2;
    check("resume_frame_cnt", 32'(frame_cnt), exp_fc % 256);

    // Asynchronous reset in the middle of DATA.
    push(8'h5A, 1'b0);
    repeat (3 + 3 * CPB) step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("async_rst_rd", 32'(fif.fifo_rd), 32'd0);
    fq.delete();
    sb.delete();
    rx_active      = 1'b0;
    fif.fifo_empty = 1'b1;
    exp_fc         = 0;
    repeat (2) step();
    rst = 1'b1;
    rc0 = rd_count;
    bad = 1'b0;
    repeat (30) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0 || frame_cnt !== 8'd0) bad = 1'b1;
    end
    check("post_rst_idle", 32'(bad), 32'd0);
    check("post_rst_no_rd", rd_count - rc0, 0);

    // 256 frames in FIFO-sized batches: frame_cnt wraps back to zero.
    for (int k = 0; k < 32; k++) begin
      for (int j = 0; j < 8; j++) begin
        b = 8'(k * 8 + j);
        push(b, ^b);
      end
      wait_done(1000, 1'b1);
      exp_fc += 8;
      check("wrap_frame_cnt", 32'(frame_cnt), exp_fc % 256);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
